// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder with a memory-mapped register file.
// Word 0 is a read-only ID register; words 1..NUM_REGS-1 are R/W with byte strobes.
module axi4_lite_slave_regs #(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = 32'h0A41_0001
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int          IDX_W       = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT  = 32'(NUM_REGS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t      wstate_q, wstate_d;
    state_t      rstate_q, rstate_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] araddr_q, araddr_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic [IDX_W-1:0] wrIdx;
    logic [IDX_W-1:0] rdIdx;
    logic             wrOk;
    logic             rdOk;

    function automatic logic addrLegal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr < ADDR_LIMIT);
    endfunction

    // Word 0 is the ID register, so it is never a legal write target.
    assign wrIdx = awaddr_q[2 +: IDX_W];
    assign rdIdx = araddr_q[2 +: IDX_W];
    assign wrOk  = addrLegal(awaddr_q) && (wrIdx != '0);
    assign rdOk  = addrLegal(araddr_q);

    assign AWREADY = (wstate_q == ADDR);
    assign WREADY  = (wstate_q == DATA);
    assign BVALID  = (wstate_q == RESP);
    assign BRESP   = bresp_q;
    assign ARREADY = (rstate_q == ADDR);
    assign RVALID  = (rstate_q == RESP);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        bresp_d  = bresp_q;
        regs_d   = regs_q;
        case (wstate_q)
            IDLE: begin
                if (AWVALID) begin
                    wstate_d = ADDR;
                end
            end
            ADDR: begin
                awaddr_d = AWADDR;
                wstate_d = DATA;
            end
            DATA: begin
                if (WVALID) begin
                    if (wrOk) begin
                        for (int b = 0; b < 4; b++) begin
                            if (WSTRB[b]) begin
                                regs_d[wrIdx][8*b +: 8] = WDATA[8*b +: 8];
                            end
                        end
                    end
                    bresp_d  = wrOk ? RESP_OKAY : RESP_SLVERR;
                    wstate_d = RESP;
                end
            end
            RESP: begin
                if (BREADY) begin
                    wstate_d = IDLE;
                end
            end
            default: wstate_d = IDLE;
        endcase
    end

    // The fetch samples regs_q, so a same-cycle write commit is not yet visible.
    always_comb begin
        rstate_d = rstate_q;
        araddr_d = araddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            IDLE: begin
                if (ARVALID) begin
                    rstate_d = ADDR;
                end
            end
            ADDR: begin
                araddr_d = ARADDR;
                rstate_d = DATA;
            end
            DATA: begin
                if (!rdOk) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    rdata_d = (rdIdx == '0) ? ID_VALUE : regs_q[rdIdx];
                    rresp_d = RESP_OKAY;
                end
                rstate_d = RESP;
            end
            RESP: begin
                if (RREADY) begin
                    rstate_d = IDLE;
                end
            end
            default: rstate_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q <= IDLE;
            rstate_q <= IDLE;
            awaddr_q <= '0;
            araddr_q <= '0;
            bresp_q  <= '0;
            rresp_q  <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            awaddr_q <= awaddr_d;
            araddr_q <= araddr_d;
            bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Randomized self-checking bench for axi4_lite_slave_regs against an array-based
// model of the register map and its response rules.
module tb_axi4_lite_slave_regs;

    localparam int          NUM_REGS = 16;
    localparam logic [31:0] ID_VALUE = 32'h0A41_0001;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] model [NUM_REGS];

    axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Reference model: the register map as a plain array plus the address rules.
    function automatic bit legal(input logic [31:0] addr, input bit isWrite);
        if (addr % 4 != 0) return 1'b0;
        if (addr >= NUM_REGS * 4) return 1'b0;
        if (isWrite && addr == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [1:0] expResp(input logic [31:0] addr, input bit isWrite);
        return legal(addr, isWrite) ? 2'b00 : 2'b10;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    endfunction

    function automatic void modelWrite(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb);
        int idx;
        if (!legal(addr, 1'b1)) return;
        idx = int'(addr >> 2);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        if (!legal(addr, 1'b0)) return '0;
        if (addr == 0) return ID_VALUE;
        return model[int'(addr >> 2)];
    endfunction

    // Write transaction: W is presented awDelay cycles before AW; BREADY is held low
    // for `hold` cycles of BVALID.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold, input int awDelay,
                            output logic [1:0] resp);
        int  n;
        int  inResp;
        bit  done;
        logic aw, w, b;
        resp = 2'b00;
        @(posedge ACLK); #1;
        WDATA = data; WSTRB = strb; WVALID = 1'b1; BREADY = (hold == 0);
        for (int k = 0; k < awDelay; k++) begin
            @(negedge ACLK);
            compared++;
            if (WREADY !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL wready_before_aw: got %b expected 0", WREADY);
            end
            @(posedge ACLK); #1;
        end
        AWADDR = addr; AWVALID = 1'b1;
        n = 0; inResp = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge ACLK);
            aw = AWREADY; w = WREADY; b = BVALID;
            if (b) begin
                compared++;
                if (inResp == 0) begin
                    resp = BRESP;
                    if (n != 3) begin
                        mismatched++;
                        $display("[TB] FAIL bvalid_latency: got cycle %0d expected 3", n);
                    end
                end else if (BRESP !== resp) begin
                    mismatched++;
                    $display("[TB] FAIL bresp_stable: got %b expected %b", BRESP, resp);
                end
                inResp++;
            end
            @(posedge ACLK); #1;
            if (aw) AWVALID = 1'b0;
            if (w) WVALID = 1'b0;
            if (b && BREADY) done = 1'b1;
            else if (b && inResp >= hold) BREADY = 1'b1;
            n++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        compared++;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL write_timeout: got no response expected BVALID handshake");
        end else begin
            @(negedge ACLK);
            if (BVALID !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bvalid_drop: got %b expected 0", BVALID);
            end
        end
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        int  n;
        int  inResp;
        bit  done;
        logic ar, r;
        data = '0; resp = 2'b00;
        @(posedge ACLK); #1;
        ARADDR = addr; ARVALID = 1'b1; RREADY = (hold == 0);
        n = 0; inResp = 0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge ACLK);
            ar = ARREADY; r = RVALID;
            if (r) begin
                compared++;
                if (inResp == 0) begin
                    data = RDATA; resp = RRESP;
                    if (n != 3) begin
                        mismatched++;
                        $display("[TB] FAIL rvalid_latency: got cycle %0d expected 3", n);
                    end
                end else if (RDATA !== data || RRESP !== resp) begin
                    mismatched++;
                    $display("[TB] FAIL rdata_stable: got %h/%b expected %h/%b",
                             RDATA, RRESP, data, resp);
                end
                inResp++;
            end
            @(posedge ACLK); #1;
            if (ar) ARVALID = 1'b0;
            if (r && RREADY) done = 1'b1;
            else if (r && inResp >= hold) RREADY = 1'b1;
            n++;
        end
        ARVALID = 1'b0;
        compared++;
        if (!done) begin
            mismatched++;
            $display("[TB] FAIL read_timeout: got no data expected RVALID handshake");
        end else begin
            @(negedge ACLK);
            if (RVALID !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rvalid_drop: got %b expected 0", RVALID);
            end
        end
        RREADY = 1'b0;
    endtask

    task automatic checkWrite(input string name, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input int hold, input int awDelay);
        logic [1:0] resp;
        do_write(addr, data, strb, hold, awDelay, resp);
        compared++;
        if (resp !== expResp(addr, 1'b1)) begin
            mismatched++;
            $display("[TB] FAIL %s bresp @%h: got %b expected %b", name, addr, resp,
                     expResp(addr, 1'b1));
        end
        modelWrite(addr, data, strb);
    endtask

    task automatic checkRead(input string name, input logic [31:0] addr, input int hold);
        logic [31:0] data;
        logic [1:0]  resp;
        do_read(addr, hold, data, resp);
        compared++;
        if (data !== modelRead(addr) || resp !== expResp(addr, 1'b0)) begin
            mismatched++;
            $display("[TB] FAIL %s read @%h: got %h/%b expected %h/%b", name, addr, data, resp,
                     modelRead(addr), expResp(addr, 1'b0));
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        modelReset();
        repeat (3) @(negedge ACLK);
        compared++;
        if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA} !== 41'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %b%b%b %b %b%b %b %h expected all zero",
                     AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA);
        end
        ARESETN = 1'b1;
        checkRead("reset_id", 32'h0, 0);
        checkRead("reset_word1", 32'h4, 0);
    endtask

    task automatic test_write_basic();
        logic [31:0] data;
        logic [1:0]  resp;
        checkWrite("basic_full", 32'h8, 32'hDEADBEEF, 4'hF, 0, 0);
        checkWrite("basic_strb", 32'h8, 32'h11223344, 4'b0101, 0, 0);
        do_read(32'h8, 0, data, resp);
        compared++;
        if (data !== 32'hDE22BE44 || resp !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL basic_readback: got %h/%b expected de22be44/00", data, resp);
        end
        checkWrite("wstrb_zero", 32'h8, 32'hFFFFFFFF, 4'h0, 0, 0);
        checkRead("wstrb_zero", 32'h8, 0);
    endtask

    task automatic test_errors();
        logic [31:0] errAddr [4];
        errAddr = '{32'h0, 32'h6, 32'h40, 32'h8000_0008};
        for (int i = 0; i < 4; i++) begin
            checkWrite("err_write", errAddr[i], 32'hCAFEF00D, 4'hF, 0, 0);
        end
        checkRead("err_id", 32'h0, 0);
        checkRead("err_word2", 32'h8, 0);
        checkRead("err_oob", 32'h40, 0);
        checkRead("err_misaligned", 32'h6, 0);
    endtask

    task automatic test_w_before_aw();
        checkWrite("w_first", 32'h14, $urandom, 4'hF, 0, 3);
        checkRead("w_first", 32'h14, 0);
    endtask

    task automatic test_backpressure();
        checkWrite("hold_write", 32'h18, $urandom, 4'hF, 5, 0);
        checkRead("hold_read", 32'h18, 5);
        checkWrite("hold_err_write", 32'h3, $urandom, 4'hF, 5, 0);
    endtask

    task automatic test_concurrent();
        logic [31:0] data;
        logic [1:0]  wresp;
        logic [1:0]  rresp;
        logic [31:0] oldValue;
        checkWrite("conc_setup", 32'hC, 32'h0, 4'hF, 0, 0);
        oldValue = modelRead(32'hC);
        fork
            do_write(32'hC, 32'h5, 4'hF, 0, 0, wresp);
            do_read(32'hC, 0, data, rresp);
        join
        modelWrite(32'hC, 32'h5, 4'hF);
        compared++;
        if (data !== oldValue || rresp !== 2'b00 || wresp !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL concurrent_old: got %h/%b/%b expected %h/00/00",
                     data, rresp, wresp, oldValue);
        end
        checkRead("concurrent_new", 32'hC, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 50; i++) begin
            addr = 32'($urandom_range(0, NUM_REGS)) << 2;
            if ($urandom_range(0, 4) == 0) addr = addr | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                checkWrite("random", addr, $urandom, 4'($urandom_range(0, 15)),
                           $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                checkRead("random", addr, $urandom_range(0, 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        checkWrite("mid_setup", 32'h10, 32'h12345678, 4'hF, 0, 0);
        @(posedge ACLK); #1;
        AWADDR = 32'h10; AWVALID = 1'b1;
        WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b0; BREADY = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 AWVALID = 1'b0;
        @(negedge ACLK);
        compared++;
        if (WREADY !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_in_data: got WREADY=%b expected 1", WREADY);
        end
        WVALID = 1'b1;
        ARESETN = 1'b0;
        modelReset();
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            compared++;
            if (BVALID !== 1'b0 || WREADY !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_reset_idle: got %b%b expected 00", BVALID, WREADY);
            end
        end
        ARESETN = 1'b1; WVALID = 1'b0; BREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            compared++;
            if (BVALID !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL mid_no_bvalid: got %b expected 0", BVALID);
            end
        end
        checkRead("mid_target", 32'h10, 0);
        checkWrite("mid_after", 32'h10, 32'hA5A55A5A, 4'hF, 0, 0);
        checkRead("mid_after", 32'h10, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_errors();
        test_w_before_aw();
        test_backpressure();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
